// File: rtl/iscas_vector_sequencer.sv
// iscas_vector_sequencer
//
// Applies stored stimulus vectors one at a time to a combinational ISCAS85
// benchmark core (default sizing: c432, 36 inputs / 7 outputs). For each
// vector it holds dut_in for SETTLE_CYCLES edges, captures dut_out and emits
// one result word on a valid/ready stream.
//
// Optional feature: define SEQ_SIGNATURE_EN to build an OUT_WIDTH-bit
// rotate-XOR MISR over the captured outputs on sig_out. Without the macro,
// sig_out is tied to 0.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   load_we/addr/data   vector memory write (only honoured in IDLE/DONE)
//   start, vec_count    begin a run of vec_count vectors (IDLE/DONE only)
//   dut_in              registered stimulus to the core (MSB = N1)
//   dut_out             core outputs (MSB = N223)
//   res_valid/ready     result stream handshake
//   res_data, res_index captured outputs and the vector index they belong to
//   busy                high while a run is in progress
//   done                sticky completion flag, cleared by the next run start
//   sig_out             output signature (0 unless SEQ_SIGNATURE_EN)
module iscas_vector_sequencer #(
  parameter int VEC_WIDTH     = 36,
  parameter int OUT_WIDTH     = 7,
  parameter int VEC_DEPTH     = 32,
  parameter int ADDR_W        = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_we,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [VEC_WIDTH-1:0] load_data,
  input  logic                 start,
  input  logic [ADDR_W:0]      vec_count,
  output logic [VEC_WIDTH-1:0] dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [ADDR_W-1:0]    res_index,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] sig_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W+1)'(VEC_DEPTH);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [VEC_WIDTH-1:0]   mem [VEC_DEPTH];
  logic [ADDR_W-1:0]      idx;
  logic [ADDR_W-1:0]      last_idx;
  logic [7:0]             settle_cnt;
  logic                   idle_like;
  logic [ADDR_W:0]        eff_count;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign eff_count = (vec_count > DEPTH_L) ? DEPTH_L : vec_count;

  // Memory is never reset; writes outside the populated depth are dropped.
  // A write coinciding with start lands here before APPLY reads it.
  always_ff @(posedge clk) begin
    if (rst_n && idle_like && load_we && ({1'b0, load_addr} < DEPTH_L)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dut_in     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (vec_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Keep the last index rather than the count so the EMIT
              // comparison stays ADDR_W wide.
              last_idx <= ADDR_W'(eff_count - 1'b1);
              idx      <= '0;
              done     <= 1'b0;
              busy     <= 1'b1;
              state    <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          dut_in     <= mem[idx];
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          res_data  <= dut_out;
          res_index <= idx;
          res_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (idx == last_idx) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_APPLY;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_SIGNATURE_EN
  logic [OUT_WIDTH-1:0] sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (idle_like && start) begin
      sig <= '0;
    end else if (state == S_CAPTURE) begin
      sig <= {sig[OUT_WIDTH-2:0], sig[OUT_WIDTH-1]} ^ dut_out;
    end
  end

  assign sig_out = sig;
`else
  assign sig_out = '0;
`endif

endmodule

// File: tb/tb_iscas_vector_sequencer.sv
// Self-checking bench for iscas_vector_sequencer. The core is stubbed as
// dut_out = dut_in[6:0]; expected results come from a model of the vector
// memory and the run rules (one result per vector, indices in order).
module tb_iscas_vector_sequencer;

  localparam int VW     = 36;
  localparam int OW     = 7;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [VW-1:0] load_data;
  logic          start;
  logic [AW:0]   vec_count;
  logic [VW-1:0] dut_in;
  logic [OW-1:0] dut_out;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
  logic [AW-1:0] res_index;
  logic          busy;
  logic          done;
  logic [OW-1:0] sig_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0] mem_m [DEPTH];
  logic [OW-1:0] sig_m;

  always #5 clk = ~clk;

  assign dut_out = dut_in[6:0];

  iscas_vector_sequencer #(
    .VEC_WIDTH    (VW),
    .OUT_WIDTH    (OW),
    .VEC_DEPTH    (DEPTH),
    .ADDR_W       (AW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .start    (start),
    .vec_count(vec_count),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_index(res_index),
    .busy     (busy),
    .done     (done),
    .sig_out  (sig_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rotate-left by one, then fold in the new capture.
  function automatic logic [OW-1:0] misr(input logic [OW-1:0] s, input logic [OW-1:0] d);
    return ((s << 1) | (s >> (OW-1))) ^ d;
  endfunction

  function automatic logic [OW-1:0] sig_expect();
`ifdef SEQ_SIGNATURE_EN
    return sig_m;
`else
    return '0;
`endif
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [VW-1:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    mem_m[a]  = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Starts a run of n vectors and drains every result. Optional features:
  // first-valid latency check, a fixed stall on one index, random ready,
  // an ignored start+write mid-run, and a write in the start cycle.
  task automatic run(input int n, input bit timing, input int stall_idx, input int stall_len,
                     input bit rand_rdy, input bit inject, input bit ld,
                     input logic [AW-1:0] ld_a, input logic [VW-1:0] ld_d);
    int eff, got, m, stalled, budget, exp_st;
    bit first_seen;
    eff = (n > DEPTH) ? DEPTH : n;
    exp_st = (stall_idx >= 0 && stall_idx < eff) ? stall_len : 0;
    start     = 1'b1;
    vec_count = 6'(n);
    if (ld) begin
      load_we   = 1'b1;
      load_addr = ld_a;
      load_data = ld_d;
      mem_m[ld_a] = ld_d;
    end
    sig_m = '0;
    @(negedge clk);
    start     = 1'b0;
    load_we   = 1'b0;
    vec_count = '0;
    got = 0; m = 0; stalled = 0; first_seen = 1'b0;
    budget = 100 + eff * 60;
    while (got < eff && m < budget) begin
      check("busy_in_run", 64'(busy), 64'(1));
      check("done_cleared", 64'(done), 64'(0));
      if (inject && m == 3) begin
        start     = 1'b1;
        vec_count = 6'd1;
        load_we   = 1'b1;
        load_addr = 5'd5;
        load_data = ~mem_m[5];
      end else begin
        start   = 1'b0;
        load_we = 1'b0;
      end
      if (res_valid === 1'b1) begin
        if (!first_seen && timing) check("first_valid_latency", 64'(m), 64'(SETTLE + 2));
        first_seen = 1'b1;
        check("res_index", 64'(res_index), 64'(got));
        check("res_data", 64'(res_data), 64'(mem_m[got][OW-1:0]));
        check("dut_in_applied", 64'(dut_in), 64'(mem_m[got]));
        if (got == stall_idx && stalled < stall_len) begin
          res_ready = 1'b0;
          stalled++;
        end else if (rand_rdy && $urandom_range(0, 2) == 0) begin
          res_ready = 1'b0;
        end else begin
          res_ready = 1'b1;
          sig_m = misr(sig_m, mem_m[got][OW-1:0]);
          got++;
        end
      end else begin
        res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      m++;
    end
    res_ready = 1'b1;
    start     = 1'b0;
    load_we   = 1'b0;
    check("result_count", 64'(got), 64'(eff));
    check("stall_cycles", 64'(stalled), 64'(exp_st));
    check("done_after_run", 64'(done), 64'(1));
    check("busy_after_run", 64'(busy), 64'(0));
    check("valid_after_run", 64'(res_valid), 64'(0));
    check("sig_after_run", 64'(sig_out), 64'(sig_expect()));
    check("dut_in_held", 64'(dut_in), 64'(mem_m[eff-1]));
    repeat (2) @(negedge clk);
    check("no_extra_valid", 64'(res_valid), 64'(0));
    check("done_sticky", 64'(done), 64'(1));
    check("sig_stable", 64'(sig_out), 64'(sig_expect()));
  endtask

  initial begin
    logic [63:0] r;
    int m;
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; vec_count = '0; res_ready = 1'b1;
    sig_m = '0;

    // Reset: all outputs cleared.
    repeat (3) @(negedge clk);
    check("rst_dut_in", 64'(dut_in), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_index", 64'(res_index), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sig", 64'(sig_out), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      r = {$urandom, $urandom};
      load(AW'(i), r[VW-1:0]);
    end
    load(5'd0, 36'h0_0000_0000);
    load(5'd1, 36'hF_FFFF_FFFF);
    load(5'd2, 36'hA_AAAA_AAAA);

    // Zero-length run from IDLE goes straight to DONE.
    check("zero_done_before", 64'(done), 64'(0));
    start = 1'b1; vec_count = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("zero_no_valid", 64'(res_valid), 64'(0));
      @(negedge clk);
    end

    // Basic run with latency check.
    run(3, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("basic_last_dut_in", 64'(dut_in), 64'(36'hA_AAAA_AAAA));

    // Backpressure on index 1 for 10 cycles.
    run(3, 1'b1, 1, 10, 1'b0, 1'b0, 1'b0, '0, '0);

    // Over-length request clamps to depth; mid-run start/write ignored.
    run(40, 1'b1, -1, 0, 1'b1, 1'b1, 1'b0, '0, '0);

    // Reset during SETTLE of index 1.
    start = 1'b1; vec_count = 6'd3; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 0;
    while (res_valid !== 1'b1 && m < 50) begin
      @(negedge clk);
      m++;
    end
    check("midrst_first_valid", 64'(res_valid), 64'(1));
    @(negedge clk);
    check("midrst_busy_apply", 64'(busy), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(res_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_dut_in", 64'(dut_in), 64'(0));
    check("midrst_sig", 64'(sig_out), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_quiet", 64'(res_valid), 64'(0));
    end
    run(1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Write in the same cycle as start: the run sees the new contents.
    r = {$urandom, $urandom};
    run(2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, 5'd0, r[VW-1:0]);

    // Random-length runs with random backpressure.
    for (int k = 0; k < 4; k++) begin
      run(int'($urandom_range(1, 35)), 1'b1, -1, 0, 1'b1, 1'b0, 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iscas_vector_sequencer.md
Name: iscas_vector_sequencer

Overview:
- Sequences stimulus into a combinational ISCAS85 benchmark core (default sized for c432: 36 inputs, 7 outputs).
- Holds up to VEC_DEPTH input vectors in an internal memory and applies them one at a time.
- After each vector, waits a programmable settle interval, captures the core outputs and emits one result word per vector over a valid/ready stream.
- Sits between the aging-experiment host or loader and the benchmark core; replaces free-running per-cycle vector application with a handshaked, back-pressurable run.

Parameters:
- VEC_WIDTH, 36, width of one input vector and of dut_in.
- OUT_WIDTH, 7, width of dut_out and res_data.
- VEC_DEPTH, 32, number of vector memory entries.
- ADDR_W, 5, vector memory address width; VEC_DEPTH <= 2**ADDR_W.
- SETTLE_CYCLES, 2, cycles dut_in is held before capture; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_we  in  1  vector memory write strobe.
- load_addr  in  ADDR_W  vector memory write address.
- load_data  in  VEC_WIDTH  vector memory write data.
- start  in  1  begin run; sampled only in IDLE or DONE.
- vec_count  in  ADDR_W+1  number of vectors to apply; sampled with start.
- dut_in  out  VEC_WIDTH  registered stimulus to the core (MSB maps to N1).
- dut_out  in  OUT_WIDTH  core outputs (MSB = N223).
- res_valid  out  1  result word valid.
- res_ready  in  1  result consumer ready.
- res_data  out  OUT_WIDTH  captured core outputs.
- res_index  out  ADDR_W  vector index of res_data.
- busy  out  1  high in APPLY, SETTLE, CAPTURE and EMIT.
- done  out  1  high in DONE; sticky until the next start or reset.
- sig_out  out  OUT_WIDTH  output signature (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - dut_in, res_valid, res_data, res_index, busy, done, sig_out and internal counters are cleared to 0.
  - Vector memory is not cleared.
  - Reset mid-run abandons the run immediately; no further results are emitted.
- States are IDLE, APPLY, SETTLE, CAPTURE, EMIT and DONE.
- IDLE/DONE:
  - start=1 with vec_count=0 goes to DONE directly.
  - start=1 with vec_count>0 latches eff_count = min(vec_count, VEC_DEPTH), clears idx, clears done and goes to APPLY.
- APPLY: dut_in <= mem[idx]; settle counter <= 0; go to SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - Goes to CAPTURE when the counter reaches SETTLE_CYCLES-1, so dut_in is stable for exactly SETTLE_CYCLES edges before capture.
- CAPTURE: res_data <= dut_out, res_index <= idx, res_valid <= 1; go to EMIT.
- EMIT:
  - res_data, res_index and res_valid are held while res_ready=0.
  - On res_valid&res_ready: res_valid <= 0.
  - Then, if idx == eff_count-1, go to DONE with done <= 1; otherwise idx <= idx+1 and go to APPLY.
- Latency: start sampled at edge T gives res_valid high after edge T+2+SETTLE_CYCLES. With no backpressure, each vector takes SETTLE_CYCLES+3 cycles.
- dut_in holds the last applied vector after DONE until the next run's APPLY or reset.
- load_we:
  - Honoured only in IDLE or DONE; ignored while busy.
  - A write and start in the same cycle: the write lands first, and the run reads updated contents.
- start while busy is ignored, with no error.
- Memory reads are synchronous to APPLY; memory may be inferred as registers or RAM.

Optional Feature:
- Macro: SEQ_SIGNATURE_EN.
- Defined:
  - sig_out is an OUT_WIDTH MISR, cleared on reset and on an accepted start.
  - At each CAPTURE it updates as sig <= {sig[OUT_WIDTH-2:0], sig[OUT_WIDTH-1]} ^ dut_out.
  - It remains stable in DONE.
- Not defined: sig_out is tied to 0 and no MISR logic is synthesised.

Test Plan:
- Reset/load: hold rst_n=0 3 cycles → all outputs 0, state IDLE. Load mem[0]=36'h0_0000_0000, mem[1]=36'hF_FFFF_FFFF, mem[2]=36'hA_AAAA_AAAA.
- Basic run: vec_count=3, res_ready=1, stub dut_out = dut_in[6:0]:
  - Expect results (index, data) = (0, 7'h00), (1, 7'h7F), (2, 7'h2A).
  - First res_valid at T+4 with SETTLE_CYCLES=2; done=1 after the third handshake; dut_in stays 36'hA_AAAA_AAAA.
- Backpressure: res_ready=0 for 10 cycles during index 1 → res_valid, res_data=7'h7F and res_index=1 held for 10 cycles; no index skipped or duplicated.
- Boundaries:
  - vec_count=0 → DONE next cycle, no res_valid.
  - vec_count=40 with VEC_DEPTH=32 → exactly 32 results, indices 0..31.
  - start and load_we during the run → both ignored.
- Reset mid-run: assert rst_n=0 while in SETTLE of index 1 → res_valid=0 and busy=0 next cycle. A following start with vec_count=1 reads mem[0] contents unchanged.
- SEQ_SIGNATURE_EN: the basic run gives sig_out = 7'h00 → 7'h7F → 7'h55 (rotate-XOR). Without the macro, sig_out stays 0.
